// File: rtl/data_memory_stage_if.sv
// Request/response bundle between the EX/MEM register and the MEM-stage data memory.
// The LoadCount/StoreCount signals exist only when DMEM_ACCESS_COUNT_EN is defined.
interface data_memory_stage_if;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  AccessSize;
   logic        LoadUnsigned;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Misaligned;
   logic        ErrorSticky;
   logic [31:0] ErrorAddr;
`ifdef DMEM_ACCESS_COUNT_EN
   logic [31:0] LoadCount;
   logic [31:0] StoreCount;
`endif

   modport master (
      output MemRead, MemWrite, AccessSize, LoadUnsigned, Address, WriteData,
      input  ReadData, Misaligned, ErrorSticky, ErrorAddr
`ifdef DMEM_ACCESS_COUNT_EN
      , input LoadCount, StoreCount
`endif
   );

   modport slave (
      input  MemRead, MemWrite, AccessSize, LoadUnsigned, Address, WriteData,
      output ReadData, Misaligned, ErrorSticky, ErrorAddr
`ifdef DMEM_ACCESS_COUNT_EN
      , output LoadCount, StoreCount
`endif
   );
endinterface

// File: rtl/data_memory_stage.sv
// MEM-stage data memory: byte/half/word stores, extended combinational loads, sticky misalignment record.
// Optional access counters are enabled by defining DMEM_ACCESS_COUNT_EN.
module data_memory_stage #(
   parameter int DEPTH     = 1024,
   parameter int ADDR_BITS = 10
) (
   input logic                Clk,
   input logic                Reset,
   data_memory_stage_if.slave bus
);
   typedef enum logic [1:0] {
      SIZE_BYTE     = 2'b00,
      SIZE_HALF     = 2'b01,
      SIZE_WORD     = 2'b10,
      SIZE_WORD_ALT = 2'b11
   } size_e;

   logic [31:0]          mem [DEPTH];
   size_e                size;
   logic [ADDR_BITS-1:0] word_idx;
   logic [1:0]           lane;
   logic                 misaligned_cond;
   logic                 store_en;
   logic [3:0]           byte_en;
   logic [31:0]          wdata_lanes;
   logic [31:0]          rdata_word;
   logic [7:0]           byte_sel;
   logic [15:0]          half_sel;
   logic [31:0]          load_data;
   logic                 error_sticky;
   logic [31:0]          error_addr;
   logic                 unused_addr_bits;

   assign size     = size_e'(bus.AccessSize);
   assign word_idx = bus.Address[ADDR_BITS+1:2];
   assign lane     = bus.Address[1:0];

   // Address bits above the word index are ignored so accesses wrap modulo DEPTH.
   assign unused_addr_bits = &{1'b0, bus.Address[31:ADDR_BITS+2]};

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      misaligned_cond = 1'b0;
      byte_en         = 4'b1111;
      wdata_lanes     = bus.WriteData;
      case (size)
         SIZE_BYTE: begin
            byte_en     = 4'b0001 << lane;
            wdata_lanes = {4{bus.WriteData[7:0]}};
         end
         SIZE_HALF: begin
            misaligned_cond = lane[0];
            byte_en         = lane[1] ? 4'b1100 : 4'b0011;
            wdata_lanes     = {2{bus.WriteData[15:0]}};
         end
         default: misaligned_cond = (lane != 2'b00);
      endcase
   end

   assign bus.Misaligned = (bus.MemRead | bus.MemWrite) & misaligned_cond;
   assign store_en       = bus.MemWrite & ~bus.Misaligned & ~Reset;

   // NOTE: the array is deliberately not reset so it still maps onto block RAM with byte enables.
   always_ff @(posedge Clk) begin
      if (store_en) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
         end
      end
   end

   // Zero-latency read; a same-cycle store becomes visible only after the edge.
   assign rdata_word = mem[word_idx];
   assign byte_sel   = rdata_word[{lane, 3'b000} +: 8];
   assign half_sel   = lane[1] ? rdata_word[31:16] : rdata_word[15:0];

   always_comb begin
      load_data = '0;
      case (size)
         SIZE_BYTE: load_data = {{24{~bus.LoadUnsigned & byte_sel[7]}}, byte_sel};
         SIZE_HALF: load_data = {{16{~bus.LoadUnsigned & half_sel[15]}}, half_sel};
         default:   load_data = rdata_word;
      endcase
      if (!bus.MemRead || misaligned_cond) load_data = '0;
   end

   assign bus.ReadData = load_data;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         error_sticky <= 1'b0;
         error_addr   <= '0;
      end else if (bus.Misaligned) begin
         error_sticky <= 1'b1;
         if (!error_sticky) error_addr <= bus.Address;
      end
   end

   assign bus.ErrorSticky = error_sticky;
   assign bus.ErrorAddr   = error_addr;

`ifdef DMEM_ACCESS_COUNT_EN
   logic [31:0] load_count;
   logic [31:0] store_count;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         load_count  <= '0;
         store_count <= '0;
      end else begin
         if (bus.MemRead & ~bus.Misaligned)  load_count  <= load_count + 32'd1;
         if (bus.MemWrite & ~bus.Misaligned) store_count <= store_count + 32'd1;
      end
   end

   assign bus.LoadCount  = load_count;
   assign bus.StoreCount = store_count;
`endif
endmodule

// File: doc/data_memory_stage.md
Name: data_memory_stage

Overview:
- MEM-stage data memory of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the ALU address and store data, and performs byte, halfword or word stores into an internal word array.
- Returns sign- or zero-extended load data, which the MEM/WB register captures as ReadIn on the next Clk edge.
- Detects misaligned accesses and keeps a sticky error record for debug.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- ADDR_BITS, 10, log2(DEPTH); word index width.

Ports:
- Clk  input  1  pipeline clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- MemRead  input  1  load request from EX/MEM.
- MemWrite  input  1  store request from EX/MEM.
- AccessSize  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- LoadUnsigned  input  1  1 = zero-extend sub-word loads; 0 = sign-extend.
- Address  input  32  byte address (ALU result).
- WriteData  input  32  store data (rt value); sub-word data is taken from the low bits.
- ReadData  output  32  combinational load result, feeds MEM/WB ReadIn.
- Misaligned  output  1  combinational; current access is misaligned.
- ErrorSticky  output  1  registered; set by any misaligned access.
- ErrorAddr  output  32  registered; Address of the first misaligned access since reset.

Behaviour:
- Word index = Address[ADDR_BITS+1:2]. Address bits above that are ignored, so accesses wrap modulo DEPTH words.
- Byte order is little-endian: Address[1:0]=0 selects bits [7:0]. For halfwords, Address[1]=0 selects [15:0] and Address[1]=1 selects [31:16].
- Misaligned condition:
  - halfword with Address[0]=1;
  - word with Address[1:0]!=0;
  - byte accesses are never misaligned.
- Misaligned = (MemRead|MemWrite) & misaligned condition.
- Store:
  - Occurs at posedge Clk when MemWrite=1, Misaligned=0 and Reset=0.
  - Only the selected byte lanes are written; all other lanes are preserved.
  - A misaligned store writes nothing.
- Load:
  - ReadData is purely combinational from the current array contents; there is zero-cycle latency inside this block.
  - Byte/half loads are extended to 32 bits per LoadUnsigned.
  - ReadData = 0 when MemRead=0 or when the load is misaligned.
- MemRead=1 and MemWrite=1 together:
  - The store occurs at the edge (if aligned).
  - ReadData shows the pre-edge contents during that cycle and the new contents after the edge.
- Back-to-back store then load to the same address: the load in the next cycle sees the stored value. No bypass is needed.
- Error tracking:
  - ErrorSticky is set at posedge when Misaligned=1.
  - ErrorAddr is captured at that same edge only if ErrorSticky was 0 beforehand; later faults do not overwrite it.
  - Both hold until Reset.
- Reset:
  - ErrorSticky=0 and ErrorAddr=0.
  - Array contents are NOT cleared, so BRAM inference is preserved; contents are undefined until written.
  - A store presented in the same cycle as Reset is suppressed.
  - ReadData and Misaligned remain combinational during reset.

Optional Feature:
- DMEM_ACCESS_COUNT_EN.
- When defined, adds two outputs:
  - LoadCount output 32: increments at posedge for each aligned access with MemRead=1.
  - StoreCount output 32: increments for each aligned access with MemWrite=1.
- Counter details:
  - Both counters increment together when both requests are asserted.
  - Both wrap 0xFFFFFFFF to 0.
  - Both reset to 0 on Reset.
  - Misaligned accesses are not counted.
- When not defined, the ports and counter logic are absent and behaviour is otherwise identical.

Test Plan:
1. Word store 0xDEADBEEF at 0x10, then word load from 0x10 -> ReadData=0xDEADBEEF, Misaligned=0.
2. After scenario 1, byte store 0x7F at 0x12, then word load from 0x10 -> 0xDE7FBEEF. Byte load from 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE.
3. Half load from 0x12 signed -> 0xFFFFDE7F. Half store 0x1234 at 0x10, then word load from 0x10 -> 0xDE7F1234.
4. Word store 0x11111111 at 0x21 -> Misaligned=1 and memory unchanged; word load from 0x20 returns prior contents. ErrorSticky=1 and ErrorAddr=0x21. A second misaligned half load at 0x33 leaves ErrorAddr=0x21. Reset -> ErrorSticky=0, ErrorAddr=0.
5. Store 0xCAFEF00D to word index DEPTH (address 4*DEPTH), then load from 0x0 -> 0xCAFEF00D (wrap). Store asserted with Reset=1 -> no write occurs.
6. With DMEM_ACCESS_COUNT_EN defined: 3 aligned loads, 2 aligned stores, 1 misaligned store -> LoadCount=3, StoreCount=2. Preload StoreCount to 0xFFFFFFFF via repeated stores (or force), then one store -> StoreCount=0.
